// File: rtl/calculator_stack_p_if.sv
// Command/status bundle for the stack calculator: one {cmd,payload} word in,
// registered top-of-stack, depth and sticky flags out.
interface calculator_stack_p_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH+3:0] data;
  logic [WIDTH-1:0] result;
  logic [DW-1:0]    depth;
  logic             stackOverflow;
  logic             stackUnderflow;
  logic             dataOverflow;
  logic             unexpectedDone;
  logic             protocolError;
  logic             correct;
  logic             finished;

  modport master (
    output data,
    input  result, depth, stackOverflow, stackUnderflow, dataOverflow,
           unexpectedDone, protocolError, correct, finished
  );

  modport slave (
    input  data,
    output result, depth, stackOverflow, stackUnderflow, dataOverflow,
           unexpectedDone, protocolError, correct, finished
  );
endinterface

// File: rtl/calculator_stack_p.sv
// Parametrised RPN stack calculator: evaluates one command word per clock on a
// DEPTH-entry LIFO and reports top-of-stack, depth and sticky completion/error flags.
module calculator_stack_p #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                ck,
  input  logic                rst_l,
  calculator_stack_p_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0]    FULL    = DW'(DEPTH);
  localparam logic [DW-1:0]    ONE     = DW'(1);
  localparam logic [DW-1:0]    TWO     = DW'(2);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_START = 4'h1;
  localparam logic [3:0] CMD_ENTER = 4'h2;
  localparam logic [3:0] CMD_ARITH = 4'h4;
  localparam logic [3:0] CMD_DONE  = 4'h8;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_SWAP = 8'h08;
  localparam logic [7:0] OP_NEG  = 8'h10;
  localparam logic [7:0] OP_POP  = 8'h20;
  localparam logic [7:0] OP_OR   = 8'h40;
  localparam logic [7:0] OP_DUP  = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] stack_reg  [DEPTH];
  logic [WIDTH-1:0] stack_next [DEPTH];
  logic [DW-1:0]    depth_reg, depth_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             sovf_reg, sovf_next;
  logic             sunf_reg, sunf_next;
  logic             dovf_reg, dovf_next;
  logic             udone_reg, udone_next;
  logic             perr_reg, perr_next;
  logic             correct_reg, correct_next;
  logic             finished_reg, finished_next;

  logic [3:0]       cmd;
  logic [WIDTH-1:0] payload;
  logic [7:0]       op;
  logic [AW-1:0]    top_idx, nxt_idx, push_idx, res_idx;
  logic [WIDTH-1:0] t_val, n_val, sum, diff, neg;
  logic             ovf_add, ovf_sub, ovf_neg;
  logic             has1, has2, full, go_err;

  assign cmd     = bus.data[WIDTH+3:WIDTH];
  assign payload = bus.data[WIDTH-1:0];
  assign op      = payload[7:0];

  assign has1     = (depth_reg >= ONE);
  assign has2     = (depth_reg >= TWO);
  assign full     = (depth_reg == FULL);
  assign top_idx  = AW'(depth_reg - ONE);
  assign nxt_idx  = AW'(depth_reg - TWO);
  assign push_idx = AW'(depth_reg);

  // Operand reads are masked when absent so an empty slot never leaks into a result.
  assign t_val = has1 ? stack_reg[top_idx] : '0;
  assign n_val = has2 ? stack_reg[nxt_idx] : '0;
  assign sum   = n_val + t_val;
  assign diff  = n_val - t_val;
  assign neg   = '0 - t_val;

  assign ovf_add = (n_val[WIDTH-1] == t_val[WIDTH-1]) && (sum[WIDTH-1] != n_val[WIDTH-1]);
  assign ovf_sub = (n_val[WIDTH-1] != t_val[WIDTH-1]) && (diff[WIDTH-1] != n_val[WIDTH-1]);
  assign ovf_neg = (t_val == MIN_VAL);

  always_comb begin
    state_next    = state_reg;
    depth_next    = depth_reg;
    stack_next    = stack_reg;
    sovf_next     = sovf_reg;
    sunf_next     = sunf_reg;
    dovf_next     = dovf_reg;
    udone_next    = udone_reg;
    perr_next     = perr_reg;
    correct_next  = correct_reg;
    finished_next = finished_reg;
    go_err        = 1'b0;

    // START outside RUN always opens a fresh transaction, whatever came before.
    if (cmd == CMD_START && state_reg != S_RUN) begin
      stack_next[0] = payload;
      depth_next    = ONE;
      sovf_next     = 1'b0;
      sunf_next     = 1'b0;
      dovf_next     = 1'b0;
      udone_next    = 1'b0;
      perr_next     = 1'b0;
      correct_next  = 1'b0;
      finished_next = 1'b0;
      state_next    = S_RUN;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd == CMD_DONE) begin
            udone_next = 1'b1;
            go_err     = 1'b1;
          end else if (cmd != CMD_NOP) begin
            perr_next = 1'b1;
            go_err    = 1'b1;
          end
        end
        S_RUN: begin
          case (cmd)
            CMD_NOP: begin
            end
            CMD_ENTER: begin
              if (full) begin
                sovf_next = 1'b1;
                go_err    = 1'b1;
              end else begin
                stack_next[push_idx] = payload;
                depth_next           = depth_reg + ONE;
              end
            end
            CMD_ARITH: begin
              case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  if (!has2) begin
                    sunf_next = 1'b1;
                    go_err    = 1'b1;
                  end else begin
                    depth_next = depth_reg - ONE;
                    case (op)
                      OP_ADD: begin
                        stack_next[nxt_idx] = sum;
                        if (ovf_add) dovf_next = 1'b1;
                      end
                      OP_SUB: begin
                        stack_next[nxt_idx] = diff;
                        if (ovf_sub) dovf_next = 1'b1;
                      end
                      OP_AND:  stack_next[nxt_idx] = n_val & t_val;
                      default: stack_next[nxt_idx] = n_val | t_val;
                    endcase
                  end
                end
                OP_SWAP: begin
                  if (!has2) begin
                    sunf_next = 1'b1;
                    go_err    = 1'b1;
                  end else begin
                    stack_next[nxt_idx] = t_val;
                    stack_next[top_idx] = n_val;
                  end
                end
                OP_NEG: begin
                  if (!has1) begin
                    sunf_next = 1'b1;
                    go_err    = 1'b1;
                  end else begin
                    stack_next[top_idx] = neg;
                    if (ovf_neg) dovf_next = 1'b1;
                  end
                end
                OP_POP: begin
                  if (!has1) begin
                    sunf_next = 1'b1;
                    go_err    = 1'b1;
                  end else begin
                    depth_next = depth_reg - ONE;
                  end
                end
                OP_DUP: begin
                  if (!has1) begin
                    sunf_next = 1'b1;
                    go_err    = 1'b1;
                  end else if (full) begin
                    sovf_next = 1'b1;
                    go_err    = 1'b1;
                  end else begin
                    stack_next[push_idx] = t_val;
                    depth_next           = depth_reg + ONE;
                  end
                end
                default: begin
                  perr_next = 1'b1;
                  go_err    = 1'b1;
                end
              endcase
            end
            CMD_DONE: begin
              finished_next = 1'b1;
              state_next    = S_DONE;
              if (depth_reg == ONE) begin
                correct_next = !dovf_reg;
              end else begin
                udone_next   = 1'b1;
                correct_next = 1'b0;
              end
            end
            default: begin
              perr_next = 1'b1;
              go_err    = 1'b1;
            end
          endcase
        end
        default: begin
        end
      endcase
    end

    if (go_err) begin
      state_next    = S_ERROR;
      finished_next = 1'b1;
      correct_next  = 1'b0;
    end
  end

  // Registered top of stack tracks the post-command stack image.
  assign res_idx = AW'(depth_next - ONE);

  always_comb begin
    result_next = '0;
    if (depth_next != '0) result_next = stack_next[res_idx];
  end

  always_ff @(posedge ck) begin
    if (!rst_l) begin
      state_reg    <= S_IDLE;
      depth_reg    <= '0;
      result_reg   <= '0;
      sovf_reg     <= 1'b0;
      sunf_reg     <= 1'b0;
      dovf_reg     <= 1'b0;
      udone_reg    <= 1'b0;
      perr_reg     <= 1'b0;
      correct_reg  <= 1'b0;
      finished_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      depth_reg    <= depth_next;
      result_reg   <= result_next;
      sovf_reg     <= sovf_next;
      sunf_reg     <= sunf_next;
      dovf_reg     <= dovf_next;
      udone_reg    <= udone_next;
      perr_reg     <= perr_next;
      correct_reg  <= correct_next;
      finished_reg <= finished_next;
    end
  end

  // Entry contents need no reset: depth alone decides what is visible.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
    always_ff @(posedge ck) begin
      stack_reg[gi] <= stack_next[gi];
    end
  end

  assign bus.result         = result_reg;
  assign bus.depth          = depth_reg;
  assign bus.stackOverflow  = sovf_reg;
  assign bus.stackUnderflow = sunf_reg;
  assign bus.dataOverflow   = dovf_reg;
  assign bus.unexpectedDone = udone_reg;
  assign bus.protocolError  = perr_reg;
  assign bus.correct        = correct_reg;
  assign bus.finished       = finished_reg;
endmodule

// File: tb/tb_calculator_stack_p.sv
// Directed bench for calculator_stack_p (DEPTH=4): the driver queues the expected
// response per command word, a monitor pops and compares after every clock edge.
module tb_calculator_stack_p;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int EW    = WIDTH + DW + 7;

  localparam logic [3:0] NOP = 4'h0, STA = 4'h1, ENT = 4'h2, ARI = 4'h4, DON = 4'h8;
  localparam logic [15:0] ADD = 16'h01, SUB = 16'h02, AND_ = 16'h04, SWP = 16'h08;
  localparam logic [15:0] NEG = 16'h10, POP = 16'h20, OR_ = 16'h40, DUP = 16'h80;
  // flag vector order: {sovf, sunf, dovf, udone, perr, correct, finished}
  localparam logic [6:0] F0 = 7'b0000000, FIN = 7'b0000001, COR = 7'b0000010;
  localparam logic [6:0] PER = 7'b0000100, UD = 7'b0001000, DOV = 7'b0010000;
  localparam logic [6:0] SUN = 7'b0100000, SOV = 7'b1000000;

  logic ck = 1'b0;
  logic rst_l = 1'b0;
  always #5 ck = ~ck;

  calculator_stack_p_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  calculator_stack_p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ck    (ck),
    .rst_l (rst_l),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q [$];
  string         name_q [$];
  int            tests  = 0;
  int            failed = 0;

  task automatic step(input logic rv, input logic [3:0] c, input logic [15:0] p,
                      input logic [15:0] er, input logic [DW-1:0] ed,
                      input logic [6:0] ef, input string nm);
    @(negedge ck);
    rst_l    = rv;
    bus.data = {c, p};
    exp_q.push_back({er, ed, ef});
    name_q.push_back(nm);
  endtask

  // Monitor: outputs reflect the word sampled at the preceding edge.
  initial begin
    logic [EW-1:0] exp_v, act_v;
    string nm;
    forever begin
      @(posedge ck);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {bus.result, bus.depth, bus.stackOverflow, bus.stackUnderflow,
                 bus.dataOverflow, bus.unexpectedDone, bus.protocolError,
                 bus.correct, bus.finished};
        tests++;
        if (act_v !== exp_v) begin
          failed++;
          $display("FAIL %s: got result=%h depth=%0d flags=%b, want result=%h depth=%0d flags=%b",
                   nm, act_v[EW-1 -: WIDTH], act_v[DW+6:7], act_v[6:0],
                   exp_v[EW-1 -: WIDTH], exp_v[DW+6:7], exp_v[6:0]);
        end else begin
          $display("ok   %s: result=%h depth=%0d flags=%b",
                   nm, act_v[EW-1 -: WIDTH], act_v[DW+6:7], act_v[6:0]);
        end
      end
    end
  end

  initial begin
    bus.data = '0;
    // reset state
    step(0, NOP, 16'h0, 16'h0, 0, F0, "reset0");
    step(0, NOP, 16'h0, 16'h0, 0, F0, "reset1");
    // 1: push/pop/add/done
    step(1, STA, 16'h1, 16'h1, 1, F0, "t1_start");
    step(1, ENT, 16'h2, 16'h2, 2, F0, "t1_enter2");
    step(1, ENT, 16'h3, 16'h3, 3, F0, "t1_enter3");
    step(1, ARI, POP,   16'h2, 2, F0, "t1_pop");
    step(1, ARI, ADD,   16'h3, 1, F0, "t1_add");
    step(1, DON, 16'h0, 16'h3, 1, FIN | COR, "t1_done");
    step(1, ENT, 16'h9, 16'h3, 1, FIN | COR, "t1_done_ignores_enter");
    // 2: overflow at DEPTH=4
    step(1, STA, 16'h1, 16'h1, 1, F0, "t2_start");
    step(1, ENT, 16'h2, 16'h2, 2, F0, "t2_enter2");
    step(1, ENT, 16'h3, 16'h3, 3, F0, "t2_enter3");
    step(1, ENT, 16'h4, 16'h4, 4, F0, "t2_enter4");
    step(1, ENT, 16'h5, 16'h4, 4, SOV | FIN, "t2_enter_full");
    step(1, ENT, 16'h6, 16'h4, 4, SOV | FIN, "t2_error_frozen");
    step(1, ARI, ADD,   16'h4, 4, SOV | FIN, "t2_error_ignores_arith");
    // 3: signed overflow
    step(1, STA, 16'h7FFF, 16'h7FFF, 1, F0, "t3_start");
    step(1, ENT, 16'h0001, 16'h0001, 2, F0, "t3_enter");
    step(1, ARI, ADD,      16'h8000, 1, DOV, "t3_add_ovf");
    step(1, DON, 16'h0,    16'h8000, 1, DOV | FIN, "t3_done_dirty");
    step(1, STA, 16'h8000, 16'h8000, 1, F0, "t3_start_min");
    step(1, ARI, NEG,      16'h8000, 1, DOV, "t3_neg_min");
    step(1, ENT, 16'h0001, 16'h0001, 2, DOV, "t3_enter1");
    step(1, ARI, SUB,      16'h7FFF, 1, DOV, "t3_sub_ovf");
    step(1, DON, 16'h0,    16'h7FFF, 1, DOV | FIN, "t3_done2");
    // 4: sub/dup/or
    step(1, STA, 16'h5, 16'h0005, 1, F0, "t4_start");
    step(1, ENT, 16'h9, 16'h0009, 2, F0, "t4_enter");
    step(1, ARI, SUB,   16'hFFFC, 1, F0, "t4_sub");
    step(1, ARI, DUP,   16'hFFFC, 2, F0, "t4_dup");
    step(1, ARI, OR_,   16'hFFFC, 1, F0, "t4_or");
    step(1, DON, 16'h0, 16'hFFFC, 1, FIN | COR, "t4_done");
    // remaining ops, empty stack, DUP underflow
    step(1, STA, 16'h00F0, 16'h00F0, 1, F0, "ops_start");
    step(1, ENT, 16'h0F3C, 16'h0F3C, 2, F0, "ops_enter");
    step(1, ARI, AND_,     16'h0030, 1, F0, "ops_and");
    step(1, ENT, 16'h0005, 16'h0005, 2, F0, "ops_enter5");
    step(1, ARI, SWP,      16'h0030, 2, F0, "ops_swap");
    step(1, ARI, SUB,      16'hFFD5, 1, F0, "ops_sub_neg");
    step(1, ARI, NEG,      16'h002B, 1, F0, "ops_neg");
    step(1, ARI, POP,      16'h0000, 0, F0, "ops_pop_empty");
    step(1, NOP, 16'h0,    16'h0000, 0, F0, "ops_nop");
    step(1, ARI, DUP,      16'h0000, 0, SUN | FIN, "ops_dup_empty");
    // DUP at full
    step(1, STA, 16'h1, 16'h1, 1, F0, "dupf_start");
    step(1, ENT, 16'h2, 16'h2, 2, F0, "dupf_e2");
    step(1, ENT, 16'h3, 16'h3, 3, F0, "dupf_e3");
    step(1, ENT, 16'h4, 16'h4, 4, F0, "dupf_e4");
    step(1, ARI, DUP,   16'h4, 4, SOV | FIN, "dupf_dup_full");
    // illegal op / cmd
    step(1, STA,  16'h2,  16'h2, 1, F0, "badop_start");
    step(1, ARI,  16'h03, 16'h2, 1, PER | FIN, "badop");
    step(1, STA,  16'h3,  16'h3, 1, F0, "badcmd_start");
    step(1, 4'h5, 16'h0,  16'h3, 1, PER | FIN, "badcmd");
    // 5: underflow, bare ENTER, early DONE, DONE in IDLE, START in RUN
    step(1, STA, 16'h4, 16'h4, 1, F0, "t5_start");
    step(1, ARI, ADD,   16'h4, 1, SUN | FIN, "t5_add_underflow");
    step(0, NOP, 16'h0, 16'h0, 0, F0, "t5_reset");
    step(1, ENT, 16'h1, 16'h0, 0, PER | FIN, "t5_idle_enter");
    step(1, STA, 16'h1, 16'h1, 1, F0, "t5_start2");
    step(1, ENT, 16'h2, 16'h2, 2, F0, "t5_enter2");
    step(1, DON, 16'h0, 16'h2, 2, UD | FIN, "t5_done_depth2");
    step(0, NOP, 16'h0, 16'h0, 0, F0, "t5_reset2");
    step(1, DON, 16'h0, 16'h0, 0, UD | FIN, "t5_idle_done");
    step(1, STA, 16'h1, 16'h1, 1, F0, "t5_start3");
    step(1, STA, 16'h2, 16'h1, 1, PER | FIN, "t5_start_in_run");
    // 6: reset mid-RUN overrides a START, then recovery from ERROR
    step(1, STA, 16'h1, 16'h1, 1, F0, "t6_start");
    step(1, ENT, 16'h2, 16'h2, 2, F0, "t6_enter");
    step(0, STA, 16'h9, 16'h0, 0, F0, "t6_reset_mid_run");
    step(1, NOP, 16'h0, 16'h0, 0, F0, "t6_idle_nop");
    step(1, ENT, 16'h5, 16'h0, 0, PER | FIN, "t6_idle_enter");
    step(1, STA, 16'h6, 16'h6, 1, F0, "t6_restart");
    @(negedge ck);
    bus.data = '0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge ck);
    if (exp_q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
